main_memory_burst: RTL and testbench

//   Parametrised, clocked main-memory model behind the cache. Serves one outstanding

---
 rtl/main_memory_burst.sv | 162 ++++++++++++++++
 tb/tb_main_memory_burst.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_burst.sv
// Clocked main-memory model: one outstanding line request, programmable latency,
// critical-word-first wrapping read bursts and atomic full-line writes.
module main_memory_burst #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 32,
   parameter int DEPTH      = 256,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_write_i,
   input  logic [ADDR_W-1:0]            req_addr_i,
   input  logic [DATA_W*LINE_WORDS-1:0] req_wdata_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic [DATA_W-1:0]            resp_rdata_o,
   output logic                         resp_last_o,
   output logic                         resp_is_write_o,
   output logic                         busy_o,
   output logic [1:0]                   dbg_state_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [IDX_W-1:0] OFF_MASK  = IDX_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("main_memory_burst: LATENCY must be at least 1");
      end
   endgenerate

   // Handshakes: a request transfers on an edge where req_valid_i & req_ready_o;
   // a beat transfers on an edge where resp_valid_o & resp_ready_i. Unaccepted
   // requests and beats are held stable by their producer.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

   state_e                      state_q;
   logic [LAT_W-1:0]            lat_q;
   logic [IDX_W-1:0]            base_q;
   logic [IDX_W-1:0]            off_q;
   logic [IDX_W-1:0]            beat_q;
   logic                        wr_q;
   logic [DATA_W*LINE_WORDS-1:0] wdata_q;
   logic                        req_ready_q;
   logic                        resp_valid_q;
   logic [DATA_W-1:0]           resp_rdata_q;
   logic                        resp_last_q;
   logic                        resp_is_write_q;
   logic                        busy_q;

   logic [IDX_W-1:0]            req_idx;
   logic [IDX_W-1:0]            rd_idx_first;
   logic [IDX_W-1:0]            rd_idx_next;
   logic                        commit;
   logic [DATA_W-1:0]           mem_rd [DEPTH];

   generate
      if (ADDR_W > IDX_W) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^req_addr_i[ADDR_W-1:IDX_W];
      end
   endgenerate

   assign req_idx      = req_addr_i[IDX_W-1:0];
   assign rd_idx_first = base_q | off_q;
   assign rd_idx_next  = base_q | ((off_q + beat_q + IDX_W'(1)) & OFF_MASK);
   // The line write lands on the same edge that moves WAIT -> RESP.
   assign commit       = (state_q == S_WAIT) && (lat_q == '0) && wr_q;

   // Storage is never reset: each word powers up holding its own index.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [IDX_W-1:0] WORD_IDX = IDX_W'(i);
      localparam int               SLICE    = i % LINE_WORDS;
      logic [DATA_W-1:0] word_q = DATA_W'(i);

      always_ff @(posedge clk) begin
         if (commit && ((WORD_IDX & ~OFF_MASK) == base_q)) begin
            word_q <= wdata_q[SLICE*DATA_W +: DATA_W];
         end
      end

      assign mem_rd[i] = word_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         lat_q           <= '0;
         base_q          <= '0;
         off_q           <= '0;
         beat_q          <= '0;
         wr_q            <= 1'b0;
         wdata_q         <= '0;
         req_ready_q     <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_rdata_q    <= '0;
         resp_last_q     <= 1'b0;
         resp_is_write_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid_i && req_ready_q) begin
                  state_q     <= S_WAIT;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  base_q      <= req_idx & ~OFF_MASK;
                  off_q       <= req_idx & OFF_MASK;
                  wr_q        <= req_write_i;
                  wdata_q     <= req_wdata_i;
                  lat_q       <= LAT_W'(LATENCY - 1);
                  beat_q      <= '0;
               end
            end
            S_WAIT: begin
               if (lat_q == '0) begin
                  state_q         <= S_RESP;
                  resp_valid_q    <= 1'b1;
                  resp_is_write_q <= wr_q;
                  resp_last_q     <= wr_q || (LINE_WORDS == 1);
                  resp_rdata_q    <= wr_q ? '0 : mem_rd[rd_idx_first];
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  if (resp_last_q) begin
                     state_q         <= S_IDLE;
                     req_ready_q     <= 1'b1;
                     busy_q          <= 1'b0;
                     resp_valid_q    <= 1'b0;
                     resp_rdata_q    <= '0;
                     resp_last_q     <= 1'b0;
                     resp_is_write_q <= 1'b0;
                  end else begin
                     beat_q       <= beat_q + IDX_W'(1);
                     resp_rdata_q <= mem_rd[rd_idx_next];
                     resp_last_q  <= (beat_q + IDX_W'(1)) == LAST_BEAT;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o     = req_ready_q;
   assign resp_valid_o    = resp_valid_q;
   assign resp_rdata_o    = resp_rdata_q;
   assign resp_last_o     = resp_last_q;
   assign resp_is_write_o = resp_is_write_q;
   assign busy_o          = busy_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench for main_memory_burst: default build (a) plus a
// LINE_WORDS=1 / LATENCY=1 build (b), each with its own expected-beat queue.
module tb_main_memory_burst;

   logic clk;
   logic rst_n;

   logic        req_valid_a, req_ready_a, req_write_a;
   logic [31:0] req_addr_a;
   logic [31:0] req_wdata_a;
   logic        resp_valid_a, resp_ready_a, resp_last_a, resp_is_write_a, busy_a;
   logic [7:0]  resp_rdata_a;
   logic [1:0]  dbg_state_a;

   logic        req_valid_b, req_ready_b, req_write_b;
   logic [31:0] req_addr_b;
   logic [7:0]  req_wdata_b;
   logic        resp_valid_b, resp_ready_b, resp_last_b, resp_is_write_b, busy_b;
   logic [7:0]  resp_rdata_b;
   logic [1:0]  dbg_state_b;

   // Beat encoding: {is_write, last, data}
   logic [9:0] exp_a[$];
   logic [9:0] exp_b[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   main_memory_burst dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_write_i(req_write_a),
      .req_addr_i(req_addr_a), .req_wdata_i(req_wdata_a),
      .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready_a), .resp_rdata_o(resp_rdata_a),
      .resp_last_o(resp_last_a), .resp_is_write_o(resp_is_write_a), .busy_o(busy_a),
      .dbg_state_o(dbg_state_a)
   );

   main_memory_burst #(.LINE_WORDS(1), .LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_write_i(req_write_b),
      .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b),
      .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready_b), .resp_rdata_o(resp_rdata_b),
      .resp_last_o(resp_last_b), .resp_is_write_o(resp_is_write_b), .busy_o(busy_b),
      .dbg_state_o(dbg_state_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // driver: present a request on a and hold it until accepted; returns 1ns after
   // the accepting edge. exp_beats holds the read beats, beat k in byte k.
   task automatic send_a(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit exp_resp, input logic [31:0] exp_beats);
      int n;
      @(negedge clk);
      req_valid_a = 1'b1;
      req_write_a = w;
      req_addr_a  = addr;
      req_wdata_a = wdata;
      if (exp_resp) begin
         if (w) exp_a.push_back({1'b1, 1'b1, 8'h00});
         else begin
            for (int k = 0; k < 4; k++) begin
               exp_a.push_back({1'b0, (k == 3), exp_beats[k*8 +: 8]});
            end
         end
      end
      n = 0;
      while (!req_ready_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept_wait_a", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && resp_valid_a && resp_ready_a) begin
         if (exp_a.size() == 0) begin
            total_cnt++;
            $display("FAIL beat_a: got unexpected beat %h expected none",
                     {resp_is_write_a, resp_last_a, resp_rdata_a});
         end else begin
            chk("beat_a", 32'({resp_is_write_a, resp_last_a, resp_rdata_a}), 32'(exp_a.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && resp_valid_b && resp_ready_b) begin
         if (exp_b.size() == 0) begin
            total_cnt++;
            $display("FAIL beat_b: got unexpected beat %h expected none",
                     {resp_is_write_b, resp_last_b, resp_rdata_b});
         end else begin
            chk("beat_b", 32'({resp_is_write_b, resp_last_b, resp_rdata_b}), 32'(exp_b.pop_front()));
         end
      end
   end

   initial begin
      int n;
      rst_n        = 1'b0;
      req_valid_a  = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
      resp_ready_a = 1'b1;
      req_valid_b  = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
      resp_ready_b = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready",  32'(req_ready_a),     32'd0);
      chk("rst_resp_valid", 32'(resp_valid_a),    32'd0);
      chk("rst_rdata",      32'(resp_rdata_a),    32'd0);
      chk("rst_last",       32'(resp_last_a),     32'd0);
      chk("rst_is_write",   32'(resp_is_write_a), 32'd0);
      chk("rst_busy",       32'(busy_a),          32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("req_ready_after_release", 32'(req_ready_a), 32'd1);

      // 1: read 0x05 -> 05,06,07,04 at T+3..T+6, ready again at T+7
      send_a(1'b0, 32'h05, 32'h0, 1'b1, 32'h04070605);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("t1_req_ready_k%0d", k),  32'(req_ready_a),  32'(k == 7));
         chk($sformatf("t1_resp_valid_k%0d", k), 32'(resp_valid_a), 32'(k >= 3 && k <= 6));
         chk($sformatf("t1_busy_k%0d", k),       32'(busy_a),       32'(k < 7));
      end

      // 5: write 0x10 then reset at T+1 -> write dropped
      send_a(1'b1, 32'h10, 32'h44332211, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk("t5_busy_before_reset", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_req_ready",  32'(req_ready_a),  32'd0);
      chk("t5_rst_resp_valid", 32'(resp_valid_a), 32'd0);
      chk("t5_rst_busy",       32'(busy_a),       32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_a(1'b0, 32'h10, 32'h0, 1'b1, 32'h13121110);

      // 2: write 0x10 {DD,CC,BB,AA}, ack at T+3, then read 0x12 -> CC,DD,AA,BB
      send_a(1'b1, 32'h10, 32'hDDCCBBAA, 1'b1, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("t2_resp_valid_k%0d", k), 32'(resp_valid_a), 32'(k == 3));
      end
      send_a(1'b0, 32'h12, 32'h0, 1'b1, 32'hBBAADDCC);

      // 3: read 0x20 with a stall on beat 1, a second request waiting meanwhile
      send_a(1'b0, 32'h20, 32'h0, 1'b1, 32'h23222120);
      n = 0;
      while (!resp_valid_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t3_first_beat_wait", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1;
      resp_ready_a = 1'b0;
      req_valid_a  = 1'b1;
      req_write_a  = 1'b0;
      req_addr_a   = 32'h30;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_stall_valid",     32'(resp_valid_a), 32'd1);
         chk("t3_stall_rdata",     32'(resp_rdata_a), 32'h21);
         chk("t3_stall_last",      32'(resp_last_a),  32'd0);
         chk("t3_stall_req_ready", 32'(req_ready_a),  32'd0);
      end
      @(posedge clk);
      #1;
      resp_ready_a = 1'b1;
      send_a(1'b0, 32'h30, 32'h0, 1'b1, 32'h33323130);

      // 4: address aliasing 0x1FF -> FF,FC,FD,FE
      send_a(1'b0, 32'h1FF, 32'h0, 1'b1, 32'hFEFDFCFF);

      // 6: one-word lines, LATENCY=1, request held high through RESP
      @(negedge clk);
      req_valid_b = 1'b1;
      req_addr_b  = 32'h03;
      exp_b.push_back({1'b0, 1'b1, 8'h03});
      n = 0;
      while (!req_ready_b && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
      req_addr_b = 32'h07;
      exp_b.push_back({1'b0, 1'b1, 8'h07});
      @(negedge clk);
      chk("t6_T0_busy",       32'(busy_b),       32'd1);
      chk("t6_T0_resp_valid", 32'(resp_valid_b), 32'd0);
      @(negedge clk);
      chk("t6_T1_resp_valid", 32'(resp_valid_b), 32'd1);
      chk("t6_T1_req_ready",  32'(req_ready_b),  32'd0);
      @(negedge clk);
      chk("t6_T2_req_ready",  32'(req_ready_b),  32'd1);
      chk("t6_T2_resp_valid", 32'(resp_valid_b), 32'd0);
      @(negedge clk);
      chk("t6_T3_req_ready",  32'(req_ready_b),  32'd0);
      chk("t6_T3_busy",       32'(busy_b),       32'd1);
      @(posedge clk);
      #1;
      req_valid_b = 1'b0;
      @(negedge clk);
      chk("t6_T4_resp_valid", 32'(resp_valid_b), 32'd1);

      // drain and report
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_outstanding", 32'(exp_a.size() + exp_b.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
